// File: rtl/mem_rq_arbiter_if.sv
// rtl/mem_rq_arbiter_if.sv - downstream line-memory request port shared by the arbiter
// master: arbiter side (drives start pulses, addresses, mask, write data)
// slave : memory-controller side (drives completions, read data, rqfull)
interface mem_rq_arbiter_if;
   logic         m_wstart_rq;
   logic [31:0]  m_waddr;
   logic [15:0]  m_wmask;
   logic [127:0] m_wdata;
   logic         m_finish_wresp;
   logic         m_rstart_rq;
   logic [31:0]  m_raddr;
   logic         m_rqfull;
   logic [127:0] m_rdat_data;
   logic         m_rdat_valid;
   logic         m_finish_mrd;

   modport master (
      output m_wstart_rq, m_waddr, m_wmask, m_wdata, m_rstart_rq, m_raddr,
      input  m_finish_wresp, m_rqfull, m_rdat_data, m_rdat_valid, m_finish_mrd
   );

   modport slave (
      input  m_wstart_rq, m_waddr, m_wmask, m_wdata, m_rstart_rq, m_raddr,
      output m_finish_wresp, m_rqfull, m_rdat_data, m_rdat_valid, m_finish_mrd
   );
endinterface

// File: rtl/mem_rq_arbiter.sv
// rtl/mem_rq_arbiter.sv - one-outstanding arbiter for dcache write/read and ifetch read
// clk, rst_n              : clock, asynchronous active-low reset
// dcw_*                   : dcache write request (addr/mask/data) and write-complete pulse
// dcr_*, icr_*            : dcache / ifetch read requests, routed read data, valid, finish
// mem                     : downstream memory port (master modport)
// arb_busy                : transaction outstanding
// arb_timeout             : sticky, watchdog retired a transaction
// arb_proto_err           : sticky, request pulse hit an already-pending slot
module mem_rq_arbiter #(
   parameter int TOUT_W = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  dcw_start_rq,
   input  logic [31:0]           dcw_in_addr,
   input  logic [15:0]           dcw_in_mask,
   input  logic [127:0]          dcw_in_data,
   output logic                  dcw_finish_wresp,
   input  logic                  dcr_start_rq,
   input  logic [31:0]           dcr_rin_addr,
   output logic [127:0]          dcr_rdat_data,
   output logic                  dcr_rdat_valid,
   output logic                  dcr_finish_mrd,
   input  logic                  icr_start_rq,
   input  logic [31:0]           icr_rin_addr,
   output logic [127:0]          icr_rdat_data,
   output logic                  icr_rdat_valid,
   output logic                  icr_finish_mrd,
   mem_rq_arbiter_if.master      mem,
   output logic                  arb_busy,
   output logic                  arb_timeout,
   output logic                  arb_proto_err
);

   typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD_D, ST_RD_I} state_t;

   localparam logic [TOUT_W-1:0] WDOG_MAX = '1;

   state_t              state_q, state_d;
   logic                last_rd_icr_q, last_rd_icr_d;
   logic [TOUT_W-1:0]   wdog_q;

   logic                dcw_pend_q, dcr_pend_q, icr_pend_q;
   logic [31:0]         dcw_addr_q, dcr_addr_q, icr_addr_q;
   logic [15:0]         dcw_mask_q;
   logic [127:0]        dcw_data_q;
   logic                timeout_q, proto_err_q;

   logic                busy, in_rd, m_fin, tout_fire, done;
   logic                dcw_clr, dcr_clr, icr_clr;
   logic                dcw_take, dcr_take, icr_take;
   logic                proto_hit;

   // Completion of the outstanding transaction, either by the memory or by the watchdog.
   // A real finish in the same cycle as the watchdog limit is treated as a normal finish.
   always_comb begin
      busy      = (state_q != ST_IDLE);
      in_rd     = (state_q == ST_RD_D) || (state_q == ST_RD_I);
      m_fin     = 1'b0;
      if (state_q == ST_WR) m_fin = mem.m_finish_wresp;
      else if (in_rd)       m_fin = mem.m_finish_mrd;
      tout_fire = busy && !m_fin && (wdog_q == WDOG_MAX);
      done      = busy && (m_fin || tout_fire);
   end

   assign dcw_clr = (state_q == ST_WR)   && done;
   assign dcr_clr = (state_q == ST_RD_D) && done;
   assign icr_clr = (state_q == ST_RD_I) && done;

   // A slot that is being released this cycle counts as free, so a new pulse
   // landing on the completion cycle is captured rather than dropped.
   assign dcw_take  = dcw_start_rq && (!dcw_pend_q || dcw_clr);
   assign dcr_take  = dcr_start_rq && (!dcr_pend_q || dcr_clr);
   assign icr_take  = icr_start_rq && (!icr_pend_q || icr_clr);
   assign proto_hit = (dcw_start_rq && !dcw_take) ||
                      (dcr_start_rq && !dcr_take) ||
                      (icr_start_rq && !icr_take);

   always_comb begin
      state_d       = state_q;
      last_rd_icr_d = last_rd_icr_q;
      case (state_q)
         ST_IDLE: begin
            if (dcw_pend_q) begin
               state_d = ST_WR;
            end else if (!mem.m_rqfull && (dcr_pend_q || icr_pend_q)) begin
               // On a tie the requester that was not served last wins.
               if (dcr_pend_q && (!icr_pend_q || last_rd_icr_q)) begin
                  state_d       = ST_RD_D;
                  last_rd_icr_d = 1'b0;
               end else begin
                  state_d       = ST_RD_I;
                  last_rd_icr_d = 1'b1;
               end
            end
         end
         default: begin
            if (done) state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         last_rd_icr_q <= 1'b1;
         wdog_q        <= '0;
         timeout_q     <= 1'b0;
         proto_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_rd_icr_q <= last_rd_icr_d;
         // Held at zero in IDLE, so it reads zero on the first busy cycle.
         wdog_q        <= busy ? wdog_q + 1'b1 : '0;
         timeout_q     <= timeout_q | tout_fire;
         proto_err_q   <= proto_err_q | proto_hit;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dcw_pend_q <= 1'b0;
         dcr_pend_q <= 1'b0;
         icr_pend_q <= 1'b0;
         dcw_addr_q <= '0;
         dcw_mask_q <= '0;
         dcw_data_q <= '0;
         dcr_addr_q <= '0;
         icr_addr_q <= '0;
      end else begin
         if (dcw_take)     dcw_pend_q <= 1'b1;
         else if (dcw_clr) dcw_pend_q <= 1'b0;
         if (dcr_take)     dcr_pend_q <= 1'b1;
         else if (dcr_clr) dcr_pend_q <= 1'b0;
         if (icr_take)     icr_pend_q <= 1'b1;
         else if (icr_clr) icr_pend_q <= 1'b0;
         if (dcw_take) begin
            dcw_addr_q <= dcw_in_addr;
            dcw_mask_q <= dcw_in_mask;
            dcw_data_q <= dcw_in_data;
         end
         if (dcr_take) dcr_addr_q <= dcr_rin_addr;
         if (icr_take) icr_addr_q <= icr_rin_addr;
      end
   end

   // Start pulse is the first busy cycle, recognised by the freshly cleared watchdog.
   assign mem.m_wstart_rq = (state_q == ST_WR) && (wdog_q == '0);
   assign mem.m_rstart_rq = in_rd && (wdog_q == '0);
   assign mem.m_waddr     = (state_q == ST_WR) ? dcw_addr_q : '0;
   assign mem.m_wmask     = (state_q == ST_WR) ? dcw_mask_q : '0;
   assign mem.m_wdata     = (state_q == ST_WR) ? dcw_data_q : '0;
   assign mem.m_raddr     = (state_q == ST_RD_D) ? dcr_addr_q :
                            (state_q == ST_RD_I) ? icr_addr_q : '0;

   assign dcw_finish_wresp = dcw_clr;
   assign dcr_finish_mrd   = dcr_clr;
   assign icr_finish_mrd   = icr_clr;
   assign dcr_rdat_data    = in_rd ? mem.m_rdat_data : '0;
   assign icr_rdat_data    = in_rd ? mem.m_rdat_data : '0;
   assign dcr_rdat_valid   = (state_q == ST_RD_D) && mem.m_rdat_valid && !tout_fire;
   assign icr_rdat_valid   = (state_q == ST_RD_I) && mem.m_rdat_valid && !tout_fire;

   assign arb_busy      = busy;
   assign arb_timeout   = timeout_q;
   assign arb_proto_err = proto_err_q;

endmodule

// File: doc/mem_rq_arbiter.md
# mem_rq_arbiter

Shares the single downstream 128-bit line-memory request port between three requesters: data-cache write (dcw), data-cache read (dcr) and instruction-fill read (icr). It sits between lsu_stage / the instruction-fill path and the memory controller, and keeps exactly one memory transaction outstanding at a time. Read data is routed back only to the requester that issued the read. A watchdog recovers from lost responses.

## Interface
- TOUT_W, default 10: watchdog counter width; a transaction times out at 2^TOUT_W-1 busy cycles.

Ports:
- clk  in  1  clock; all state on its rising edge
- rst_n  in  1  asynchronous active-low reset
- dcw_start_rq  in  1  one-cycle write request pulse
- dcw_in_addr  in  32  write line address, sampled with the pulse
- dcw_in_mask  in  16  byte enables, sampled with the pulse
- dcw_in_data  in  128  write data, sampled with the pulse
- dcw_finish_wresp  out  1  one-cycle write-complete pulse
- dcr_start_rq / icr_start_rq  in  1  one-cycle read request pulse
- dcr_rin_addr / icr_rin_addr  in  32  read line address, sampled with the pulse
- dcr_rdat_data / icr_rdat_data  out  128  routed read data
- dcr_rdat_valid / icr_rdat_valid  out  1  routed read-data valid
- dcr_finish_mrd / icr_finish_mrd  out  1  one-cycle read-complete pulse
- m_wstart_rq  out  1  downstream write start pulse
- m_waddr  out  32  downstream write address
- m_wmask  out  16  downstream write mask
- m_wdata  out  128  downstream write data
- m_finish_wresp  in  1  downstream write done
- m_rstart_rq  out  1  downstream read start pulse
- m_raddr  out  32  downstream read address
- m_rqfull  in  1  downstream cannot accept a read
- m_rdat_data  in  128  downstream read data
- m_rdat_valid  in  1  downstream read data valid
- m_finish_mrd  in  1  downstream read done
- arb_busy  out  1  transaction outstanding
- arb_timeout  out  1  sticky: watchdog fired
- arb_proto_err  out  1  sticky: request pulse while own request pending

## Operation
- Each requester has one capture slot: a pending flag plus registered address, and mask/data for dcw.
- A start pulse with the slot empty sets pending and captures the fields.
- A start pulse with the slot already pending is dropped. It sets arb_proto_err, and the captured fields are unchanged.
- FSM states: IDLE, WR, RD_D, RD_I.
- In IDLE, grant priority is:
  - dcw pending → WR. Writes always win, which preserves store-before-load ordering.
  - Otherwise, if dcr/icr are pending and m_rqfull=0, grant round-robin using last_rd (reset value = icr, so dcr wins the first tie). The granted one goes to RD_D or RD_I, and last_rd is updated.
  - With m_rqfull=1, reads stay pending. Writes are unaffected.
- On entering a busy state, the FSM issues one m_wstart_rq or m_rstart_rq pulse. m_waddr/m_wmask/m_wdata/m_raddr come from the granted slot's registers and are held until the state exits.
- WR exits on m_finish_wresp: dcw_finish_wresp pulses, dcw pending clears, and the FSM returns to IDLE.
- RD_x behaviour:
  - m_rdat_data goes to both *_rdat_data outputs.
  - m_rdat_valid and m_finish_mrd are gated to the owner only; the other requester sees valid=0 and finish=0.
  - RD_x exits on m_finish_mrd.
- Watchdog:
  - The counter clears on entering a busy state and increments each busy cycle.
  - At 2^TOUT_W-1 without a finish, the owner gets a finish pulse and no rdat_valid; pending clears, arb_timeout sets, and the FSM goes to IDLE.
- Finish/valid inputs arriving in IDLE are ignored.
- Pending set and clear for the same slot in the same cycle: set wins.

## Timing
- Reset values:
  - All outputs 0.
  - FSM=IDLE, pending flags 0, counter 0, last_rd=icr.
- Pulse at cycle N:
  - pending is visible at N+1.
  - The FSM enters the busy state and m_*start_rq is high during N+2, for exactly one cycle, if the request is the winner.
- Requester-to-downstream latency is 2 cycles minimum.
- Response routing is combinational, with zero added latency:
  - rdat_valid/finish to the owner in the same cycle the m_* input is high.
  - arb_busy drops and the next grant is evaluated in the following cycle, so back-to-back start pulses are spaced at least 2 cycles apart after a finish.
- arb_busy=1 exactly while in WR/RD_D/RD_I.
- arb_timeout and arb_proto_err clear only on reset.

## Test plan
- dcw pulse: addr=0x100, mask=0xFFFF, data=0xA5…A5.
  - m_wstart_rq 2 cycles later with the same fields.
  - m_finish_wresp 5 cycles later → one dcw_finish_wresp pulse; arb_busy back to 0.
- dcw, dcr and icr pulses in the same cycle:
  - Order is write, then dcr read, then icr read.
  - Each icr/dcr gets only its own rdat_valid/finish; the non-owner's valid stays 0.
- Repeated simultaneous dcr+icr pulses for 4 rounds → grants alternate dcr, icr, dcr, icr.
- m_rqfull=1 with dcr pending → no m_rstart_rq.
  - A dcw pulse during this time proceeds.
  - Releasing m_rqfull → read issues 1 cycle later.
- TOUT_W=4, read with no finish:
  - After 15 busy cycles → owner finish pulse, no valid, arb_timeout=1.
  - A late m_finish_mrd produces no output.
- Second dcr pulse while dcr pending → arb_proto_err=1 and the original address is used.
  - Assert rst_n low mid-transaction → all outputs 0 immediately.
